crap_game_ctrl: RTL and testbench

Parametrised craps game controller, the successor to the fixed two-dice craps FSM. It sequences come-out and point phases and requests each roll from the dice generator over a req/valid handshake. It validates die values, latches the point, and optionally caps the number of point rolls. It also keeps saturating win/loss statistics and sits between the button debouncer, the dice roller and the display/LED logic.

---
 rtl/crap_pkg.sv | 22 ++
 rtl/crap_roll_eval.sv | 50 +++++
 rtl/crap_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_crap_game_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/crap_pkg.sv
// Shared types for the craps game controller: controller states and the
// classification of a single roll.
package crap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COME_OUT,
        POINT,
        POINT_ROLL,
        WIN,
        LOSE
    } state_e;

    typedef enum logic [2:0] {
        NATURAL,
        CRAPS,
        POINT_HIT,
        SEVEN_OUT,
        NONE
    } roll_class_e;

endpackage

// File: rtl/crap_roll_eval.sv
// Combinational roll classifier: checks both dice are legal, forms the sum
// and classifies it against the come-out rules or the latched point.
module crap_roll_eval
    import crap_pkg::*;
#(
    parameter int FACES = 6,
    parameter int DIE_W = 4,
    parameter int SUM_W = 5
) (
    input  logic [DIE_W-1:0] die_a_i,
    input  logic [DIE_W-1:0] die_b_i,
    input  logic [SUM_W-1:0] point_i,
    input  logic             point_phase_i,
    output logic             legal_o,
    output logic [SUM_W-1:0] sum_o,
    output logic [2:0]       cls_o
);

    localparam logic [SUM_W-1:0] NAT   = SUM_W'(FACES + 1);
    localparam logic [SUM_W-1:0] YO    = SUM_W'(2 * FACES - 1);
    localparam logic [SUM_W-1:0] BOXES = SUM_W'(2 * FACES);

    roll_class_e cls;

    function automatic logic die_ok(input logic [DIE_W-1:0] v);
        return (v != '0) && (v <= DIE_W'(FACES));
    endfunction

    assign legal_o = die_ok(die_a_i) && die_ok(die_b_i);
    assign sum_o   = SUM_W'(die_a_i) + SUM_W'(die_b_i);
    assign cls_o   = cls;

    // Naturals win before craps is considered, so tiny dice where the two
    // sets overlap still resolve deterministically.
    always_comb begin
        cls = NONE;
        if (point_phase_i) begin
            if (sum_o == point_i)
                cls = POINT_HIT;
            else if (sum_o == NAT)
                cls = SEVEN_OUT;
        end else begin
            if (sum_o == NAT || sum_o == YO)
                cls = NATURAL;
            else if (sum_o == SUM_W'(2) || sum_o == SUM_W'(3) || sum_o == BOXES)
                cls = CRAPS;
        end
    end

endmodule

// File: rtl/crap_game_ctrl.sv
// Craps game controller: sequences come-out and point phases, requests rolls
// from the dice generator, rejects illegal dice with an implicit reroll and
// keeps saturating per-game and lifetime statistics. All outputs registered.
module crap_game_ctrl
    import crap_pkg::*;
#(
    parameter int FACES     = 6,
    parameter int DIE_W     = 4,
    parameter int SUM_W     = 5,
    parameter int MAX_ROLLS = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic             new_game,
    output logic             roll_req,
    input  logic             roll_valid,
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    output logic             press,
    output logic [SUM_W-1:0] point,
    output logic             point_valid,
    output logic             win,
    output logic             lose,
    output logic             die_err,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    state_e           state_q, state_d;
    logic [SUM_W-1:0] point_q, point_d;
    logic             pv_q, pv_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic [CNT_W-1:0] lc_q, lc_d;
    logic             die_err_q, die_err_d;
    logic             press_q, press_d;
    logic             roll_req_q, roll_req_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    logic             legal;
    logic [SUM_W-1:0] sum;
    logic [2:0]       cls_raw;
    roll_class_e      cls;
    logic             accept;
    logic [CNT_W-1:0] rc_inc;
    logic             limit_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    crap_roll_eval #(
        .FACES (FACES),
        .DIE_W (DIE_W),
        .SUM_W (SUM_W)
    ) u_eval (
        .die_a_i       (die_a),
        .die_b_i       (die_b),
        .point_i       (point_q),
        .point_phase_i (state_q == POINT_ROLL),
        .legal_o       (legal),
        .sum_o         (sum),
        .cls_o         (cls_raw)
    );

    assign cls       = roll_class_e'(cls_raw);
    // roll_valid only counts while a request is outstanding.
    assign accept    = roll_req_q && roll_valid;
    assign rc_inc    = sat_inc(rc_q);
    // Point-phase rolls exclude the come-out roll, hence the minus one.
    assign limit_hit = (MAX_ROLLS != 0) && ((rc_inc - CNT_W'(1)) == CNT_W'(MAX_ROLLS));

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d   = state_q;
        point_d   = point_q;
        pv_d      = pv_q;
        rc_d      = rc_q;
        wc_d      = wc_q;
        lc_d      = lc_q;
        die_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (btn) begin
                    state_d = COME_OUT;
                    rc_d    = '0;
                end
            end
            COME_OUT, POINT_ROLL: begin
                if (accept) begin
                    if (!legal) begin
                        die_err_d = 1'b1;
                    end else begin
                        rc_d = rc_inc;
                        unique case (cls)
                            NATURAL, POINT_HIT: state_d = WIN;
                            CRAPS, SEVEN_OUT:   state_d = LOSE;
                            default: begin
                                if (state_q == COME_OUT) begin
                                    point_d = sum;
                                    pv_d    = 1'b1;
                                    state_d = POINT;
                                end else if (limit_hit) begin
                                    state_d = LOSE;
                                end else begin
                                    state_d = POINT;
                                end
                            end
                        endcase
                    end
                end
            end
            POINT: begin
                if (btn)
                    state_d = POINT_ROLL;
            end
            WIN, LOSE: begin
                if (new_game)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entering a result state retires the point and records the outcome.
        if ((state_d == WIN || state_d == LOSE) && state_d != state_q) begin
            point_d = '0;
            pv_d    = 1'b0;
            if (state_d == WIN)
                wc_d = sat_inc(wc_q);
            else
                lc_d = sat_inc(lc_q);
        end

        press_d    = (state_d == IDLE) || (state_d == POINT);
        roll_req_d = (state_d == COME_OUT) || (state_d == POINT_ROLL);
        win_d      = (state_d == WIN);
        lose_d     = (state_d == LOSE);
    end

    // State and output registers; reset wins over any in-flight handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            point_q    <= '0;
            pv_q       <= 1'b0;
            rc_q       <= '0;
            wc_q       <= '0;
            lc_q       <= '0;
            die_err_q  <= 1'b0;
            press_q    <= 1'b1;
            roll_req_q <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            point_q    <= point_d;
            pv_q       <= pv_d;
            rc_q       <= rc_d;
            wc_q       <= wc_d;
            lc_q       <= lc_d;
            die_err_q  <= die_err_d;
            press_q    <= press_d;
            roll_req_q <= roll_req_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign press       = press_q;
    assign roll_req    = roll_req_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign die_err     = die_err_q;
    assign point       = point_q;
    assign point_valid = pv_q;
    assign roll_count  = rc_q;
    assign win_cnt     = wc_q;
    assign loss_cnt    = lc_q;

endmodule

// File: tb/tb_crap_game_ctrl.sv
// Scoreboard bench for crap_game_ctrl: stimulus tasks advance a game-level
// model and queue the expected snapshot; a monitor compares whenever the
// DUT's outputs change, die_err pulses or reset was applied.
module tb_crap_game_ctrl;

    localparam int FACES     = 6;
    localparam int DIE_W     = 4;
    localparam int SUM_W     = 5;
    localparam int MAX_ROLLS = 2;
    localparam int CNT_W     = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0, btn = 1'b0, new_game = 1'b0, roll_valid = 1'b0;
    logic [DIE_W-1:0] die_a = '0, die_b = '0;
    logic roll_req, press, point_valid, win, lose, die_err;
    logic [SUM_W-1:0] point;
    logic [CNT_W-1:0] roll_count, win_cnt, loss_cnt;

    always #5 clk = ~clk;

    crap_game_ctrl #(
        .FACES(FACES), .DIE_W(DIE_W), .SUM_W(SUM_W),
        .MAX_ROLLS(MAX_ROLLS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .new_game(new_game),
        .roll_req(roll_req), .roll_valid(roll_valid),
        .die_a(die_a), .die_b(die_b), .press(press), .point(point),
        .point_valid(point_valid), .win(win), .lose(lose), .die_err(die_err),
        .roll_count(roll_count), .win_cnt(win_cnt), .loss_cnt(loss_cnt)
    );

    typedef struct packed {
        logic             press;
        logic             roll_req;
        logic             win;
        logic             lose;
        logic             die_err;
        logic [SUM_W-1:0] point;
        logic             pv;
        logic [CNT_W-1:0] rc;
        logic [CNT_W-1:0] wc;
        logic [CNT_W-1:0] lc;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;

    // Game-level model: waiting for a roll, current point (0 = none),
    // result (0 none, 1 won, 2 lost) and the three tallies.
    bit m_rolling;
    int m_res, m_point, m_rc, m_wc, m_lc;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic push(input bit err, input string tag);
        obs_t e;
        e.press    = !m_rolling && (m_res == 0);
        e.roll_req = m_rolling;
        e.win      = (m_res == 1);
        e.lose     = (m_res == 2);
        e.die_err  = err;
        e.point    = m_point[SUM_W-1:0];
        e.pv       = (m_point != 0);
        e.rc       = m_rc[CNT_W-1:0];
        e.wc       = m_wc[CNT_W-1:0];
        e.lc       = m_lc[CNT_W-1:0];
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic finish_game(input int r);
        m_res   = r;
        m_point = 0;
        if (r == 1) m_wc = sat(m_wc + 1);
        else        m_lc = sat(m_lc + 1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit with_roll);
        reset = 1'b1; roll_valid = with_roll; die_a = 4'd3; die_b = 4'd4;
        m_rolling = 0; m_res = 0; m_point = 0; m_rc = 0; m_wc = 0; m_lc = 0;
        push(0, with_roll ? "reset_with_roll" : "reset");
        cyc();
        reset = 1'b0; roll_valid = 1'b0;
    endtask

    task automatic press_btn();
        btn = 1'b1;
        if (!m_rolling && m_res == 0) begin
            if (m_point == 0) m_rc = 0;
            m_rolling = 1;
            push(0, "btn");
        end
        cyc();
        btn = 1'b0;
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        if (m_res != 0) begin
            m_res = 0;
            push(0, "new_game");
        end
        cyc();
        new_game = 1'b0;
    endtask

    task automatic give_roll(input int a, input int b);
        die_a = a[DIE_W-1:0]; die_b = b[DIE_W-1:0]; roll_valid = 1'b1;
        if (m_rolling) begin
            if (a < 1 || a > FACES || b < 1 || b > FACES) begin
                push(1, $sformatf("illegal(%0d,%0d)", a, b));
            end else begin
                int s;
                s = a + b;
                m_rc = sat(m_rc + 1);
                m_rolling = 0;
                if (m_point == 0) begin
                    if (s == FACES + 1 || s == 2 * FACES - 1)   finish_game(1);
                    else if (s == 2 || s == 3 || s == 2 * FACES) finish_game(2);
                    else m_point = s;
                end else if (s == m_point)       finish_game(1);
                else if (s == FACES + 1)         finish_game(2);
                else if (MAX_ROLLS != 0 && m_rc - 1 == MAX_ROLLS) finish_game(2);
                push(0, $sformatf("roll(%0d,%0d)", a, b));
            end
        end
        cyc();
        roll_valid = 1'b0;
    endtask

    function automatic int rand_die();
        if ($urandom_range(0, 4) == 0)
            return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(7, 15));
        return int'($urandom_range(1, FACES));
    endfunction

    // Reset seen by the DUT at the last edge, for the monitor.
    logic rst_s = 1'b0;
    always @(posedge clk) rst_s <= reset;

    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] cur;
        bit started;
        obs_t got, e;
        string tag;
        started = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {press, roll_req, win, lose};
            if (rst_s || (started && (cur !== prev || die_err === 1'b1))) begin
                started = 1;
                got = {press, roll_req, win, lose, die_err, point, point_valid,
                       roll_count, win_cnt, loss_cnt};
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event: got p/rr/w/l=%b err=%b rc=%0d, required no change",
                             cur, die_err, roll_count);
                end else begin
                    e = exp_q.pop_front();
                    tag = tag_q.pop_front();
                    if (got !== e)
                        $display("FAIL %s: got p/rr/w/l/err=%b%b%b%b%b pt=%0d pv=%b rc=%0d wc=%0d lc=%0d, required p/rr/w/l/err=%b%b%b%b%b pt=%0d pv=%b rc=%0d wc=%0d lc=%0d",
                                 tag, got.press, got.roll_req, got.win, got.lose, got.die_err,
                                 got.point, got.pv, got.rc, got.wc, got.lc,
                                 e.press, e.roll_req, e.win, e.lose, e.die_err,
                                 e.point, e.pv, e.rc, e.wc, e.lc);
                    else
                        passed++;
                end
            end
            prev = cur;
        end
    end

    initial begin : stimulus
        do_reset(0);
        // Come-out natural, then craps with an ignored btn in LOSE.
        press_btn(); give_roll(3, 4); do_new_game();
        press_btn(); give_roll(1, 1); press_btn(); do_new_game();
        // Roll while idle is ignored.
        give_roll(3, 4);
        // Point 5, miss with 8, hit with 5.
        press_btn(); give_roll(2, 3); press_btn(); give_roll(4, 4);
        press_btn(); give_roll(1, 4); do_new_game();
        // Point 6, seven-out.
        press_btn(); give_roll(2, 4); press_btn(); give_roll(3, 4); do_new_game();
        // Point 4, roll limit reached on the second point roll.
        press_btn(); give_roll(1, 3); press_btn(); give_roll(2, 3);
        press_btn(); give_roll(3, 3); do_new_game();
        // Illegal dice reroll, then yo-leven.
        press_btn(); give_roll(0, 5); give_roll(7, 1); give_roll(5, 6); do_new_game();
        // Reset during POINT_ROLL with roll_valid in the same cycle.
        press_btn(); give_roll(2, 3); press_btn(); do_reset(1);

        // Randomised play.
        repeat (600) begin
            int k;
            k = $urandom_range(0, 19);
            if (k < 4)        press_btn();
            else if (k < 14)  give_roll(rand_die(), rand_die());
            else if (k < 18)  do_new_game();
            else if (k == 18) cyc();
            else if ($urandom_range(0, 7) == 0) do_reset($urandom_range(0, 1) == 1);
        end

        // Win tally saturation.
        do_reset(0);
        repeat (300) begin
            press_btn(); give_roll(5, 6); do_new_game();
        end

        repeat (4) cyc();
        while (exp_q.size() > 0) begin
            obs_t e;
            string tag;
            e = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            $display("FAIL %s: got no response, required p/rr/w/l=%b%b%b%b rc=%0d",
                     tag, e.press, e.roll_req, e.win, e.lose, e.rc);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
